// File: rtl/cla_adder_sequencer_if.sv
// Handshake bundle for cla_adder_sequencer.
//   Two requesters (req0_*, req1_*): valid/ready handshake with operands A, B and
//   a subtract flag. One result channel (res_*): valid/ready with sum, carry out,
//   signed overflow and the id of the requester that owns the result. busy
//   reports that the sequencer is not idle.
//   master : the environment side (requesters and result consumer)
//   slave  : the sequencer side
interface cla_adder_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;
  logic             res_id;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_ovf, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_ovf, res_id, busy
  );
endinterface

// File: rtl/cla_adder_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract built around one CHUNK-bit carry-lookahead
// slice, shared round-robin between two requesters. One chunk is processed per
// cycle, LSB first, with the inter-chunk carry held in a register.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cla_adder_sequencer_if.slave (request and result handshakes, busy)
module cla_adder_sequencer #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_adder_sequencer_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = $clog2(NCHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_cout_q;
  logic             res_ovf_q;
  logic             res_id_q;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone request wins; on contention the requester that was not
  // granted last time wins.
  // ---------------------------------------------------------------------------
  logic grant;
  logic accept;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  assign bus.req0_ready = (state_q == IDLE) & bus.req0_valid & ~grant;
  assign bus.req1_ready = (state_q == IDLE) & bus.req1_valid &  grant;
  assign accept         = bus.req0_ready | bus.req1_ready;

  // ---------------------------------------------------------------------------
  // CHUNK-bit carry-lookahead slice from generate/propagate cells. Each carry is
  // the OR of every generate term propagated up to it, plus the carry-in
  // propagated through all lower bits, so no carry depends on another.
  // ---------------------------------------------------------------------------
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_g;
  logic [CHUNK-1:0] slice_p;
  logic [CHUNK:0]   slice_c;
  logic [CHUNK-1:0] slice_sum;
  logic             term;

  assign slice_a   = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign slice_b   = b_q[int'(idx_q) * CHUNK +: CHUNK];
  assign slice_g   = slice_a & slice_b;
  assign slice_p   = slice_a ^ slice_b;
  assign slice_sum = slice_p ^ slice_c[CHUNK-1:0];

  always_comb begin
    slice_c    = '0;
    term       = 1'b0;
    slice_c[0] = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      term = carry_q;
      for (int k = 0; k <= i; k++) term = term & slice_p[k];
      slice_c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = slice_g[j];
        for (int k = j + 1; k <= i; k++) term = term & slice_p[k];
        slice_c[i+1] = slice_c[i+1] | term;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM. B is stored pre-inverted for subtract and the carry register
  // is seeded with the subtract flag, giving A + ~B + 1.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_ovf_q    <= 1'b0;
      res_id_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q          <= grant ? bus.req1_a : bus.req0_a;
            b_q          <= grant ? (bus.req1_sub ? ~bus.req1_b : bus.req1_b)
                                  : (bus.req0_sub ? ~bus.req0_b : bus.req0_b);
            carry_q      <= grant ? bus.req1_sub : bus.req0_sub;
            res_id_q     <= grant;
            last_grant_q <= grant;
            idx_q        <= '0;
            state_q      <= RUN;
          end
        end
        RUN: begin
          res_sum_q[int'(idx_q) * CHUNK +: CHUNK] <= slice_sum;
          carry_q <= slice_c[CHUNK];
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDXW'(NCHUNK - 1)) begin
            res_cout_q <= slice_c[CHUNK];
            // Signed overflow: carry into the MSB differs from carry out of it.
            res_ovf_q  <= slice_c[CHUNK] ^ slice_c[CHUNK-1];
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = (state_q == DONE);
  assign bus.res_sum   = res_sum_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cla_adder_sequencer.sv
// Directed bench for cla_adder_sequencer (WIDTH=16, CHUNK=4). Expected values
// are hand-computed constants; outputs are sampled on the falling edge or
// shortly after the rising edge.
module tb_cla_adder_sequencer;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  logic g;
  logic seen;

  cla_adder_sequencer_if #(.WIDTH(16)) bus ();

  cla_adder_sequencer #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Called at a falling edge with the sequencer idle; returns at a falling edge
  // with the sequencer idle again.
  task automatic run_op(input string tag, input logic id,
                        input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_valid = 1'b1;
    end
    #1;
    check_bit({tag, "_ready"}, id ? bus.req1_ready : bus.req0_ready, 1'b1);
    @(posedge clk);                       // accepting edge
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit({tag, "_early"}, bus.res_valid, 1'b0);
    @(posedge clk);                       // fourth edge after acceptance
    @(negedge clk);
    check_bit({tag, "_valid"}, bus.res_valid, 1'b1);
    check    ({tag, "_sum"},   bus.res_sum,   exp_sum);
    check_bit({tag, "_cout"},  bus.res_cout,  exp_cout);
    check_bit({tag, "_ovf"},   bus.res_ovf,   exp_ovf);
    check_bit({tag, "_id"},    bus.res_id,    id);
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_bit({tag, "_drop"}, bus.res_valid, 1'b0);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; passed = 0; total = 0; g = 1'b0; seen = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Reset state and first contention.
    check_bit("rst_res_valid", bus.res_valid, 1'b0);
    check_bit("rst_busy",      bus.busy,      1'b0);
    check_bit("rst_ready0",    bus.req0_ready, 1'b0);
    check_bit("rst_ready1",    bus.req1_ready, 1'b0);
    check    ("rst_res_sum",   bus.res_sum,   16'h0000);
    check_bit("rst_res_id",    bus.res_id,    1'b0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check_bit("first_contend_r0", bus.req0_ready, 1'b1);
    check_bit("first_contend_r1", bus.req1_ready, 1'b0);
    bus.req0_valid = 1'b0;                // withdrawn before the edge
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check_bit("withdrawn_busy", bus.busy, 1'b0);

    // 2. Requester 0 additions.
    run_op("add_ff", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("add_7f", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_ff_wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    // 3. Requester 1 subtractions.
    run_op("sub_neg", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // 4. Continuous contention alternates grants (last grant was requester 1).
    bus.req0_a = 16'h1234; bus.req0_b = 16'h1111; bus.req0_sub = 1'b0;
    bus.req1_a = 16'h1000; bus.req1_b = 16'h0001; bus.req1_sub = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.res_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2) == 1;
      check_bit("alt_ready0", bus.req0_ready, ~g);
      check_bit("alt_ready1", bus.req1_ready, g);
      @(posedge clk);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_bit("alt_valid", bus.res_valid, 1'b1);
      check_bit("alt_id",    bus.res_id,    g);
      check    ("alt_sum",   bus.res_sum,   g ? 16'h0FFF : 16'h2345);
      check_bit("alt_no_ready_done", bus.req0_ready | bus.req1_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.res_ready = 1'b0;
    @(negedge clk);

    // 5. Result held while res_ready is low; requester 0 waits meanwhile.
    bus.req1_a = 16'h0003; bus.req1_b = 16'h0004; bus.req1_sub = 1'b0;
    bus.req1_valid = 1'b1;
    #1;
    check_bit("hold_accept1", bus.req1_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    bus.req0_a = 16'h0010; bus.req0_b = 16'h0001; bus.req0_sub = 1'b1;
    bus.req0_valid = 1'b1;
    repeat (4) @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_bit("hold_valid",  bus.res_valid,  1'b1);
      check    ("hold_sum",    bus.res_sum,    16'h0007);
      check_bit("hold_cout",   bus.res_cout,   1'b0);
      check_bit("hold_ovf",    bus.res_ovf,    1'b0);
      check_bit("hold_id",     bus.res_id,     1'b1);
      check_bit("hold_ready0", bus.req0_ready, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    #1;
    check_bit("take_no_ready0", bus.req0_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_bit("after_take_valid",  bus.res_valid,  1'b0);
    check_bit("after_take_ready0", bus.req0_ready, 1'b1);

    // 6. Asynchronous reset in RUN at chunk index 2.
    @(posedge clk);                       // requester 0 accepted
    #1;
    bus.req0_valid = 1'b0;
    @(posedge clk);                       // idx 0 -> 1
    @(posedge clk);                       // idx 1 -> 2
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("arst_busy",  bus.busy,      1'b0);
    check_bit("arst_valid", bus.res_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    bus.res_ready = 1'b0;
    check_bit("arst_no_pulse", seen, 1'b0);
    check_bit("arst_idle", bus.busy, 1'b0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check_bit("arst_contend_r0", bus.req0_ready, 1'b1);
    check_bit("arst_contend_r1", bus.req1_ready, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cla_adder_sequencer.md
Name: cla_adder_sequencer

Overview:
- Shares one CHUNK-bit carry-lookahead adder slice, built from the team's generate/propagate full-adder cells, between two requesters.
- Performs a WIDTH-bit add or subtract over WIDTH/CHUNK cycles, chaining the carry through a register.
- Sits between operand producers and the shared arithmetic slice.
- Provides round-robin arbitration, valid/ready handshakes, and a held result.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 4, adder slice width in bits; NCHUNK = WIDTH/CHUNK, must be 2 or more

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_sub  input  1  1 = A-B, 0 = A+B
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
req1_sub  input  1  1 = A-B, 0 = A+B
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_sum  output  WIDTH  sum/difference
res_cout  output  1  carry out of MSB; for subtract, 1 = no borrow
res_ovf  output  1  signed two's-complement overflow
res_id  output  1  requester that owns the result
busy  output  1  state != IDLE

Behaviour:
- Design has one clock. Reset is asynchronous, active-low, on rst_n.
- Reset state:
  - state=IDLE, chunk index=0, carry register=0, operand/result registers=0.
  - last_grant=1, so requester 0 wins the first contention.
  - res_valid=0, res_sum=0, res_cout=0, res_ovf=0, res_id=0, busy=0.
- Ready outputs are combinational:
  - reqN_ready = (state==IDLE) & reqN_valid & grant==N.
  - At most one ready is high per cycle.
- Arbitration, in IDLE only:
  - If only one request is valid, grant it.
  - If both are valid, grant !last_grant.
  - last_grant updates on acceptance.
  - Valid requests must hold operands stable until ready. Operands are sampled only on the accepting edge.
- States:
  - IDLE -> RUN on acceptance:
    - Latch A.
    - Latch B, inverted if sub.
    - Carry register = sub.
    - res_id = granted requester, index = 0.
  - RUN, one chunk per cycle, LSB chunk first:
    - Slice adds A[idx], B'[idx] and the carry register.
    - Sum slice is written to res_sum[idx].
    - Carry register takes the slice carry-out.
    - idx increments.
  - RUN, on the last chunk (idx==NCHUNK-1):
    - res_cout = slice carry-out.
    - res_ovf = carry into MSB XOR carry out of MSB.
    - Next state is DONE.
  - DONE:
    - res_valid=1. res_sum, res_cout, res_ovf and res_id are held stable.
    - On res_valid & res_ready -> IDLE and res_valid drops the next cycle.
    - No request is accepted in the same cycle the result is taken.
- Latency: res_valid rises exactly NCHUNK rising edges after the accepting edge (4 for the defaults).
- Throughput: minimum NCHUNK+2 cycles per operation.
- res_sum is undefined-but-registered during RUN. Consumers use it only while res_valid is high.
- Arithmetic wraps modulo 2^WIDTH.
- Reset mid-RUN or mid-DONE:
  - Returns immediately to the reset state.
  - The in-flight result is discarded with no res_valid pulse.
- A request deasserting valid before ready has no effect.

Test Plan:
1. Reset with no requests -> res_valid=0, busy=0, req0_ready=req1_ready=0. Assert req0_valid and req1_valid together -> req0_ready=1 first.
2. req0 add: a=0x00FF, b=0x0001 -> res_sum=0x0100, cout=0, ovf=0, id=0, res_valid exactly 4 edges after acceptance. Repeat with 0x7FFF+0x0001 -> 0x8000, ovf=1. Repeat with 0xFFFF+0x0001 -> 0x0000, cout=1, ovf=0.
3. req1 subtract: 0x0005-0x0007 -> 0xFFFE, cout=0, ovf=0, id=1. Then 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
4. Both requesters valid continuously with res_ready=1 -> grants alternate 0,1,0,1. res_id matches the grant. Neither requester is starved.
5. res_ready held low 3 cycles in DONE -> all res_* stable and no reqN_ready. Raise res_ready -> back to IDLE, next grant after one cycle.
6. Assert rst_n=0 asynchronously at RUN idx=2 -> busy=0 and res_valid=0 immediately with no result pulse. Next contention grants requester 0.
